// File: rtl/irq_controller.sv
// Edge-latching, masked, fixed-priority interrupt sequencer driving PC redirects on entry and mret.
// Latency: 2 clocks from a sampled source rise to pc_jump; single-shot redirects, no nesting.
// Backpressure: none; edges seen while a handler runs stay pending until after the return.
module irq_controller #(
    parameter int          NUM_SRC    = 4,
    parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
    parameter logic [31:0] VEC_STRIDE = 32'h0000_0010,
    localparam int         ID_W       = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic               global_en,
    input  logic               mask_we,
    input  logic [NUM_SRC-1:0] mask_in,
    input  logic [31:0]        pc,
    input  logic               mret,
    output logic               pc_jump,
    output logic [31:0]        pc_target,
    output logic [31:0]        epc,
    output logic               irq_active,
    output logic [ID_W-1:0]    irq_id,
    output logic [NUM_SRC-1:0] irq_ack,
    output logic [NUM_SRC-1:0] pending
);

    typedef enum logic [1:0] {ST_IDLE, ST_VECTOR, ST_ACTIVE, ST_RETURN} state_t;

    state_t             state, state_next;
    logic [NUM_SRC-1:0] prev_src;
    logic [NUM_SRC-1:0] mask;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] win_oh;
    logic [ID_W-1:0]    win_id;
    logic               take;
    logic               ret;

    assign rise     = irq_src & ~prev_src;
    assign eligible = pending & mask;
    assign take     = (state == ST_IDLE) && global_en && (|eligible);
    assign ret      = (state == ST_ACTIVE) && mret;

    // Scan downwards so the lowest eligible index is the last one written.
    always_comb begin
        win_id = '0;
        win_oh = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                win_id = ID_W'(i);
                win_oh = NUM_SRC'(1) << i;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (take) state_next = ST_VECTOR;
            ST_VECTOR: state_next = ST_ACTIVE;
            ST_ACTIVE: if (mret) state_next = ST_RETURN;
            ST_RETURN: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_src  <= '0;
            mask      <= '0;
            pending   <= '0;
            irq_ack   <= '0;
            pc_jump   <= 1'b0;
            pc_target <= '0;
            epc       <= '0;
            irq_id    <= '0;
        end else begin
            prev_src <= irq_src;
            if (mask_we) mask <= mask_in;
            // A fresh edge on the source being cleared wins over the clear.
            pending  <= (pending & ~(take ? win_oh : '0)) | rise;
            irq_ack  <= take ? win_oh : '0;
            pc_jump  <= take | ret;
            if (take) begin
                irq_id    <= win_id;
                epc       <= pc;
                pc_target <= VEC_BASE + 32'(win_id) * VEC_STRIDE;
            end else if (ret) begin
                pc_target <= epc;
            end
        end
    end

    assign irq_active = (state != ST_IDLE);

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: expected redirects are queued by the stimulus and checked by a monitor.
module tb_irq_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  irq_src;
    logic        global_en;
    logic        mask_we;
    logic [3:0]  mask_in;
    logic [31:0] pc;
    logic        mret;
    logic        pc_jump;
    logic [31:0] pc_target;
    logic [31:0] epc;
    logic        irq_active;
    logic [1:0]  irq_id;
    logic [3:0]  irq_ack;
    logic [3:0]  pending;

    irq_controller #(
        .NUM_SRC    (4),
        .VEC_BASE   (32'h0000_0100),
        .VEC_STRIDE (32'h0000_0010)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .irq_src    (irq_src),
        .global_en  (global_en),
        .mask_we    (mask_we),
        .mask_in    (mask_in),
        .pc         (pc),
        .mret       (mret),
        .pc_jump    (pc_jump),
        .pc_target  (pc_target),
        .epc        (epc),
        .irq_active (irq_active),
        .irq_id     (irq_id),
        .irq_ack    (irq_ack),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [31:0] tgt;
        logic [3:0]  ack;
        logic [1:0]  id;
        logic [31:0] epc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, req);
        end
    endtask

    task automatic expect_jump(input int c, input logic [31:0] tgt, input logic [3:0] ack,
                               input logic [1:0] id, input logic [31:0] e);
        exp_t x;
        x.cyc = c; x.tgt = tgt; x.ack = ack; x.id = id; x.epc = e;
        exp_q.push_back(x);
    endtask

    // Monitor: every pc_jump cycle must match the head of the queue; an overdue head is a missed jump.
    always @(negedge clk) begin
        if (pc_jump === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_jump", {31'd0, pc_jump}, 32'd0);
            end else begin
                exp_t x;
                x = exp_q.pop_front();
                chk("jump_cycle", cyc, x.cyc);
                chk("pc_target", pc_target, x.tgt);
                chk("irq_ack", {28'd0, irq_ack}, {28'd0, x.ack});
                chk("irq_id", {30'd0, irq_id}, {30'd0, x.id});
                chk("epc", epc, x.epc);
                chk("active_on_jump", {31'd0, irq_active}, 32'd1);
            end
        end else if (exp_q.size() > 0 && cyc >= exp_q[0].cyc) begin
            exp_t x;
            x = exp_q.pop_front();
            chk("missed_jump", {31'd0, pc_jump}, 32'd1);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_pc_jump"}, {31'd0, pc_jump}, 32'd0);
        chk({tag, "_pc_target"}, pc_target, 32'd0);
        chk({tag, "_epc"}, epc, 32'd0);
        chk({tag, "_irq_active"}, {31'd0, irq_active}, 32'd0);
        chk({tag, "_irq_id"}, {30'd0, irq_id}, 32'd0);
        chk({tag, "_irq_ack"}, {28'd0, irq_ack}, 32'd0);
        chk({tag, "_pending"}, {28'd0, pending}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        reset = 1'b0; irq_src = '0; global_en = 1'b0; mask_we = 1'b0;
        mask_in = '0; pc = '0; mret = 1'b0;
        tick(); tick();
        chk_zero("reset");
        reset = 1'b1;
        global_en = 1'b1;

        // mret outside a handler is ignored
        mret = 1'b1; tick(); mret = 1'b0; tick(); tick();
        chk("idle_mret_no_jump", {31'd0, pc_jump}, 32'd0);

        // Single interrupt on source 2
        mask_in = 4'b0100; mask_we = 1'b1; pc = 32'h40; tick(); mask_we = 1'b0;
        irq_src = 4'b0100; c = cyc;
        expect_jump(c + 2, 32'h120, 4'b0100, 2'd2, 32'h40);
        tick(); tick(); tick();
        chk("single_active", {31'd0, irq_active}, 32'd1);
        chk("single_epc_hold", epc, 32'h40);
        irq_src = '0; pc = 32'h44; mret = 1'b1; c = cyc;
        expect_jump(c + 1, 32'h40, 4'b0000, 2'd2, 32'h40);
        tick(); mret = 1'b0; tick(); tick();
        chk("single_idle_after", {31'd0, irq_active}, 32'd0);

        // Priority: sources 1 and 3 together, 3 queued behind the return
        mask_in = 4'hF; mask_we = 1'b1; tick(); mask_we = 1'b0;
        pc = 32'h80; irq_src = 4'b1010; c = cyc;
        expect_jump(c + 2, 32'h110, 4'b0010, 2'd1, 32'h80);
        tick(); tick();
        chk("prio_pending", {28'd0, pending}, 32'h8);
        tick();
        pc = 32'h84; mret = 1'b1; c = cyc;
        expect_jump(c + 1, 32'h80, 4'b0000, 2'd1, 32'h80);
        expect_jump(c + 3, 32'h130, 4'b1000, 2'd3, 32'h84);
        tick(); mret = 1'b0; tick(); tick(); tick();
        chk("prio_pending_drained", {28'd0, pending}, 32'h0);
        irq_src = '0; mret = 1'b1; c = cyc;
        expect_jump(c + 1, 32'h84, 4'b0000, 2'd3, 32'h84);
        tick(); mret = 1'b0; tick(); tick();

        // Masked source waits, then mask write releases it
        mask_in = 4'b0000; mask_we = 1'b1; tick(); mask_we = 1'b0;
        irq_src = 4'b0001; tick(); tick();
        chk("masked_pending", {28'd0, pending}, 32'h1);
        chk("masked_idle", {31'd0, irq_active}, 32'd0);
        pc = 32'h200; mask_in = 4'b0001; mask_we = 1'b1; c = cyc;
        expect_jump(c + 2, 32'h100, 4'b0001, 2'd0, 32'h200);
        tick(); mask_we = 1'b0; tick(); tick();
        mret = 1'b1;
        expect_jump(cyc + 1, 32'h200, 4'b0000, 2'd0, 32'h200);
        tick(); mret = 1'b0; irq_src = '0; tick(); tick();

        // global_en gating, then edges during a handler, then reset mid-handler
        global_en = 1'b0; irq_src = 4'b0001;
        tick(); tick(); tick(); tick();
        chk("gated_pending", {28'd0, pending}, 32'h1);
        chk("gated_idle", {31'd0, irq_active}, 32'd0);
        pc = 32'h300; global_en = 1'b1; c = cyc;
        expect_jump(c + 1, 32'h100, 4'b0001, 2'd0, 32'h300);
        tick(); tick();
        mask_in = 4'hF; mask_we = 1'b1; irq_src = 4'b0101;
        tick(); mask_we = 1'b0; tick();
        chk("handler_edge_pending", {28'd0, pending}, 32'h4);
        chk("handler_still_active", {31'd0, irq_active}, 32'd1);
        mret = 1'b1;
        expect_jump(c + 5, 32'h300, 4'b0000, 2'd0, 32'h300);
        expect_jump(c + 7, 32'h120, 4'b0100, 2'd2, 32'h300);
        tick(); mret = 1'b0; tick(); tick(); tick();
        chk("second_active", {31'd0, irq_active}, 32'd1);
        chk("second_id", {30'd0, irq_id}, 32'd2);
        reset = 1'b0; irq_src = '0;
        tick();
        chk_zero("midreset");
        reset = 1'b1;
        tick(); tick();
        chk("post_reset_no_jump", {31'd0, pc_jump}, 32'd0);
        chk("post_reset_pending", {28'd0, pending}, 32'd0);

        tick(); tick();
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/irq_controller.md
# irq_controller

Interrupt controller that sequences the PC counter on interrupt entry and return. It latches rising edges from up to NUM_SRC interrupt sources and applies a mask. When a source is eligible, it saves the current PC, drives a one-cycle redirect to that source's vector, and later redirects back to the saved PC on an `mret` pulse from decode. It sits between the interrupt sources and the PC counter's `jump`/`pc_target` inputs. Interrupts do not nest.

## Interface

Parameters:
- NUM_SRC, 4, number of interrupt sources (2..16)
- VEC_BASE, 32'h0000_0100, byte address of the vector for source 0
- VEC_STRIDE, 32'h0000_0010, byte spacing between consecutive vectors

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset
- irq_src  in  NUM_SRC  raw interrupt request lines, rising-edge sensitive
- global_en  in  1  global interrupt enable
- mask_we  in  1  mask register write strobe
- mask_in  in  NUM_SRC  new mask value (1 = enabled)
- pc  in  32  current PC from the PC counter
- mret  in  1  return-from-interrupt pulse from decode
- pc_jump  out  1  one-cycle redirect request to the PC counter
- pc_target  out  32  redirect address, valid while pc_jump = 1
- epc  out  32  saved return PC
- irq_active  out  1  handler in progress (state != IDLE)
- irq_id  out  clog2(NUM_SRC)  index of the source being serviced
- irq_ack  out  NUM_SRC  one-hot, one-cycle acknowledge to the serviced source
- pending  out  NUM_SRC  latched pending bits

## Operation

- Edge detect: `prev_src` is a registered copy of `irq_src`. `pending[i]` sets when `irq_src[i] & ~prev_src[i]`. `prev_src` resets to 0, so a source held high through reset is latched as an edge on the first clock after release.
- Mask register: reset value 0 (all masked). Loads `mask_in` when `mask_we` = 1.
- Eligibility: `eligible = pending & mask`. The lowest index has the highest priority. A take occurs only when state = IDLE, `global_en` = 1 and `eligible` != 0.
- FSM states are IDLE, VECTOR, ACTIVE and RETURN.
  - IDLE → VECTOR on a take. On that edge: `irq_id` ← winning index; `epc` ← `pc`; `pending[id]` clears; `irq_ack` ← one-hot(id); `pc_jump` ← 1; `pc_target` ← VEC_BASE + id*VEC_STRIDE (32-bit, wrap on overflow).
  - VECTOR → ACTIVE unconditionally. `pc_jump` and `irq_ack` return to 0.
  - ACTIVE → RETURN when `mret` = 1. On that edge: `pc_jump` ← 1 and `pc_target` ← `epc`.
  - RETURN → IDLE unconditionally. `pc_jump` returns to 0.
- `mret` is ignored in every state except ACTIVE.
- Edges arriving in VECTOR, ACTIVE or RETURN only set pending bits. They are serviced after the return.
- A new edge on the source being cleared at the take edge wins: that pending bit stays 1.
- Mask or `global_en` changes during VECTOR, ACTIVE or RETURN never abort the current handler.
- `epc`, `irq_id` and `pc_target` hold their values until the next take or return.
- Asynchronous reset, including mid-handler: state = IDLE and all registers and outputs = 0 (`pc_jump`, `pc_target`, `epc`, `irq_active`, `irq_id`, `irq_ack`, `pending`, mask, `prev_src`).

## Timing

- All outputs are registered; no combinational path from input to output.
- Latency from the edge where a rising `irq_src` is first sampled to `pc_jump` high is 2 clocks: pending sets on edge k, take on edge k+1.
- If the source is already pending and enabled when the mask is written, the take occurs on the edge after the write.
- `pc_jump` is exactly 1 cycle wide, both in VECTOR and in RETURN.
- `irq_ack` is exactly 1 cycle wide, in VECTOR only.
- `irq_active` rises with `pc_jump` on entry and falls one cycle after the return jump.
- After `mret` is sampled on edge m, the return jump is visible in cycle m..m+1. The earliest subsequent take is at edge m+2.

## Test plan

Parameters for all scenarios: NUM_SRC=4, VEC_BASE=0x100, VEC_STRIDE=0x10.

- **Reset:** assert reset mid-run → all outputs 0 and `pending` = 0. After release, `mret` pulses → `pc_jump` stays 0.
- **Single interrupt:** mask = 4'b0100, `pc` = 0x40, rise on `irq_src[2]` → 2 clocks later, for one cycle: `pc_jump` = 1, `pc_target` = 0x120, `irq_ack` = 4'b0100. `epc` = 0x40, `irq_id` = 2.
- **Priority and queued return:** mask = 0xF, `irq_src[1]` and `irq_src[3]` rise together → take id 1 with target 0x110; `pending` = 4'b1000. Then `mret` → one cycle of `pc_target` = `epc`. Two clocks after `mret`, take id 3 with target 0x130.
- **Masked source:** mask = 0, rise on `irq_src[0]` → `pending[0]` = 1 and no jump. Then write mask = 4'b0001 → jump to 0x100 on the following edge.
- **`global_en` gating:** `global_en` = 0 holds an eligible source with no jump. Setting `global_en` = 1 → take on the next edge.
- **Edges during a handler:** a source edge during ACTIVE is latched in `pending` but not taken until after the return. Reset asserted during ACTIVE returns the block to IDLE with all state cleared.
